// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/lap/clear controller.
// The LAP state is only reachable when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

  localparam int BCD_W            = 24;
  localparam int TICK_DIV_DEFAULT = 500000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_e;

  // RUN and LAP are the states in which the prescaler advances.
  function automatic logic is_counting(input sw_state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_press_det.sv
// Raw active-low key -> 2-flop synchronizer -> history flop -> one-cycle press pulse.
// Every flop resets to the released level so reset release never looks like a press.
module key_press_det (
  input  logic clk_i,
  input  logic ar_ni,
  input  logic key_n_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Synchronizer chain followed by the edge-history flop.
  always_ff @(posedge clk_i or negedge ar_ni) begin
    if (!ar_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign press_o = hist_q & ~sync2_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, count-tick prescaler, clear request and lap-freeze display mux.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             ar,
  input  logic             key_run_n,
  input  logic             key_lap_n,
  input  logic [BCD_W-1:0] bcd_live,
  output logic             ctr_en,
  output logic             ctr_clr,
  output logic [BCD_W-1:0] bcd_disp,
  output logic             running,
  output logic             lap_active
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic          run_press;
  logic          lap_press;
  sw_state_e     state_q;
  sw_state_e     state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          ctr_en_d;
  logic          ctr_clr_d;
  logic          tick;

  key_press_det u_run_det (
    .clk_i   (clk),
    .ar_ni   (ar),
    .key_n_i (key_run_n),
    .press_o (run_press)
  );

  key_press_det u_lap_det (
    .clk_i   (clk),
    .ar_ni   (ar),
    .key_n_i (key_lap_n),
    .press_o (lap_press)
  );

  // Next-state, prescaler and pulse decode; run always takes priority over lap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_press) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (run_press) state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_press) state_d = LAP;
`endif
        else state_d = RUN;
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (run_press)      state_d = PAUSE;
        else if (lap_press) state_d = RUN;
        else                state_d = LAP;
      end
`endif
      PAUSE: begin
        if (run_press)      state_d = RUN;
        else if (lap_press) state_d = IDLE;
        else                state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase

    tick = (presc_q == PRESC_MAX);
    if ((state_d == IDLE) || ((state_q == IDLE) && (state_d == RUN))) begin
      presc_d = '0;
    end else if (is_counting(state_q)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end

    // A wrap on the edge that leaves RUN/LAP is swallowed, not issued late.
    ctr_en_d  = is_counting(state_q) && is_counting(state_d) && tick;
    ctr_clr_d = (state_q == PAUSE) && (state_d == IDLE);
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q <= IDLE;
      presc_q <= '0;
      ctr_en  <= 1'b0;
      ctr_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ctr_en  <= ctr_en_d;
      ctr_clr <= ctr_clr_d;
      running <= is_counting(state_d);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [BCD_W-1:0] lap_q;

  // Freeze the live value on RUN->LAP, before any same-cycle increment lands.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else begin
      lap_active <= (state_d == LAP);
      if ((state_q == RUN) && (state_d == LAP)) lap_q <= bcd_live;
      else                                      lap_q <= lap_q;
    end
  end

  assign bcd_disp = (state_q == LAP) ? lap_q : bcd_live;
`else
  assign lap_active = 1'b0;
  assign bcd_disp   = bcd_live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4.
// Lap scenarios follow STOPWATCH_LAP_EN; otherwise the lap key must be ignored in RUN.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        ar = 1'b0;
  logic        key_run_n = 1'b1;
  logic        key_lap_n = 1'b1;
  logic [23:0] bcd_live = 24'h000000;
  logic [23:0] bcd_disp;
  logic        ctr_en;
  logic        ctr_clr;
  logic        running;
  logic        lap_active;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .ar         (ar),
    .key_run_n  (key_run_n),
    .key_lap_n  (key_lap_n),
    .bcd_live   (bcd_live),
    .ctr_en     (ctr_en),
    .ctr_clr    (ctr_clr),
    .bcd_disp   (bcd_disp),
    .running    (running),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected key(s) low until the edge on which the FSM reacts.
  task automatic press(input logic run, input logic lap);
    if (run) key_run_n = 1'b0;
    if (lap) key_lap_n = 1'b0;
    step(3);
    key_run_n = 1'b1;
    key_lap_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    ar = 1'b0;
    bcd_live = 24'hABCDEF;
    #12;
    checks++;
    if ({ctr_en, ctr_clr, running, lap_active} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000", {ctr_en, ctr_clr, running, lap_active});
    end
    checks++;
    if (bcd_disp !== 24'hABCDEF) begin
      failures++;
      $display("FAIL reset_disp: got %h expected abcdef", bcd_disp);
    end
    @(posedge clk);
    #3 ar = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if ({ctr_en, ctr_clr, running, lap_active} !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_run();
    int bad;
    int pulses;
    bcd_live = 24'h000100;
    press(1'b1, 1'b0);
    checks++;
    if ({running, lap_active, ctr_en} !== 3'b100) begin
      failures++;
      $display("FAIL run_entry: got %b expected 100", {running, lap_active, ctr_en});
    end
    bad = 0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (ctr_en !== ((k % 4) == 0)) bad++;
      if (ctr_en === 1'b1) pulses++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tick_phase: got %0d misplaced cycles expected 0", bad);
    end
    checks++;
    if (pulses != 5) begin
      failures++;
      $display("FAIL tick_count: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_lap();
    int pulses;
`ifdef STOPWATCH_LAP_EN
    bcd_live = 24'h000123;
    press(1'b0, 1'b1);
    checks++;
    if ({running, lap_active} !== 2'b11) begin
      failures++;
      $display("FAIL lap_entry: got %b expected 11", {running, lap_active});
    end
    checks++;
    if (bcd_disp !== 24'h000123) begin
      failures++;
      $display("FAIL lap_capture: got %h expected 000123", bcd_disp);
    end
    bcd_live = 24'h000130;
    #1;
    checks++;
    if (bcd_disp !== 24'h000123) begin
      failures++;
      $display("FAIL lap_freeze: got %h expected 000123", bcd_disp);
    end
`else
    press(1'b0, 1'b1);
    checks++;
    if ({running, lap_active} !== 2'b10) begin
      failures++;
      $display("FAIL lap_ignored: got %b expected 10", {running, lap_active});
    end
    checks++;
    if (bcd_disp !== bcd_live) begin
      failures++;
      $display("FAIL disp_live: got %h expected %h", bcd_disp, bcd_live);
    end
`endif
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (ctr_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL lap_counting: got %0d pulses expected 2", pulses);
    end
`ifdef STOPWATCH_LAP_EN
    press(1'b0, 1'b1);
    checks++;
    if ({running, lap_active} !== 2'b10) begin
      failures++;
      $display("FAIL lap_release: got %b expected 10", {running, lap_active});
    end
    checks++;
    if (bcd_disp !== 24'h000130) begin
      failures++;
      $display("FAIL lap_track: got %h expected 000130", bcd_disp);
    end
`endif
  endtask

  task automatic test_clear();
    int bad;
    press(1'b1, 1'b0);
    checks++;
    if ({running, ctr_en} !== 2'b00) begin
      failures++;
      $display("FAIL pause_entry: got %b expected 00", {running, ctr_en});
    end
    step(2);
    press(1'b0, 1'b1);
    checks++;
    if ({ctr_clr, running, ctr_en} !== 3'b100) begin
      failures++;
      $display("FAIL clr_pulse: got %b expected 100", {ctr_clr, running, ctr_en});
    end
    step(1);
    checks++;
    if (ctr_clr !== 1'b0) begin
      failures++;
      $display("FAIL clr_width: got %b expected 0", ctr_clr);
    end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if ({ctr_en, ctr_clr, running} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_after_clr: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_pause_resume();
    int bad;
    press(1'b1, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL rerun_entry: got %b expected 1", running);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (ctr_en !== 1'b0) bad++;
    end
    key_run_n = 1'b0;
    step(1);
    if (ctr_en !== 1'b1) bad++;
    step(1);
    if (ctr_en !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL prepause_ticks: got %0d misplaced cycles expected 0", bad);
    end
    step(1);
    key_run_n = 1'b1;
    checks++;
    if ({running, ctr_en} !== 2'b00) begin
      failures++;
      $display("FAIL midperiod_pause: got %b expected 00", {running, ctr_en});
    end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if ({running, ctr_en} !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pause_hold: got %0d active cycles expected 0", bad);
    end
    press(1'b1, 1'b0);
    bad = 0;
    if ({running, ctr_en} !== 2'b10) bad++;
    step(1);
    if (ctr_en !== 1'b0) bad++;
    step(1);
    checks++;
    if (ctr_en !== 1'b1) begin
      failures++;
      $display("FAIL resume_tick: got %b expected 1", ctr_en);
    end
    step(1);
    if (ctr_en !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL resume_phase: got %0d misplaced cycles expected 0", bad);
    end
  endtask

  task automatic test_simultaneous();
    step(4);
`ifdef STOPWATCH_LAP_EN
    bcd_live = 24'h000456;
    press(1'b0, 1'b1);
    checks++;
    if ({lap_active, bcd_disp} !== {1'b1, 24'h000456}) begin
      failures++;
      $display("FAIL lap2_capture: got %b/%h expected 1/000456", lap_active, bcd_disp);
    end
    step(4);
    press(1'b0, 1'b1);
    step(4);
`endif
    bcd_live = 24'h000789;
    press(1'b1, 1'b1);
    checks++;
    if ({running, lap_active} !== 2'b00) begin
      failures++;
      $display("FAIL run_wins: got %b expected 00", {running, lap_active});
    end
    checks++;
    if (bcd_disp !== 24'h000789) begin
      failures++;
      $display("FAIL simul_disp: got %h expected 000789", bcd_disp);
    end
`ifdef STOPWATCH_LAP_EN
    checks++;
    if (dut.lap_q !== 24'h000456) begin
      failures++;
      $display("FAIL lap_reg_kept: got %h expected 000456", dut.lap_q);
    end
`endif
  endtask

  task automatic test_async_reset();
    int bad;
    step(4);
    press(1'b1, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL prereset_run: got %b expected 1", running);
    end
`ifdef STOPWATCH_LAP_EN
    step(4);
    bcd_live = 24'h000321;
    press(1'b0, 1'b1);
    bcd_live = 24'h999999;
    #1;
    checks++;
    if ({lap_active, bcd_disp} !== {1'b1, 24'h000321}) begin
      failures++;
      $display("FAIL prereset_lap: got %b/%h expected 1/000321", lap_active, bcd_disp);
    end
`endif
    #3 ar = 1'b0;
    #1;
    checks++;
    if ({ctr_en, ctr_clr, running, lap_active} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got %b expected 0000", {ctr_en, ctr_clr, running, lap_active});
    end
    checks++;
    if (bcd_disp !== bcd_live) begin
      failures++;
      $display("FAIL async_disp: got %h expected %h", bcd_disp, bcd_live);
    end
    @(posedge clk);
    #3 ar = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if ({ctr_en, ctr_clr, running, lap_active} !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_lap();
    test_clear();
    test_pause_resume();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap/clear controller for the 6-digit BCD count-and-display chain. It turns two raw board pushbuttons into a 4-state stopwatch FSM. It generates the counter's count-enable tick from a prescaler and issues a clear request. It muxes either the live count or a frozen lap value toward the seven-segment decoders. It sits between the board keys and the counter/decoder datapath, clocked on the same system clock.

## Interface
- TICK_DIV, 500000: clocks per count tick (50 MHz → 100 Hz, hundredths); legal range ≥ 2
- clk  in  1  system clock, rising edge
- ar  in  1  asynchronous, active-low reset
- key_run_n  in  1  raw run/pause pushbutton, low = pressed
- key_lap_n  in  1  raw lap/clear pushbutton, low = pressed
- bcd_live  in  24  current counter value, digit 5 in [23:20] … digit 0 in [3:0]
- ctr_en  out  1  one-cycle count-enable pulse to the counter
- ctr_clr  out  1  one-cycle synchronous clear request to the counter
- bcd_disp  out  24  value for the decoders (live or lap)
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP

## Operation
- Reset values:
  - state IDLE; prescaler 0; lap_reg 0.
  - ctr_en, ctr_clr, running and lap_active are 0.
  - Key sync/history flops are 1 (released), so releasing reset never produces a spurious press.
  - bcd_disp = bcd_live.
- Press detection, per key:
  - 2-flop synchronizer, then a history flop.
  - press = history & ~sync2, i.e. a high→low transition.
  - One press event per falling edge. There is no auto-repeat and no debounce filter.
- FSM transitions:
  - IDLE: run → RUN, prescaler cleared. Lap is ignored.
  - RUN: run → PAUSE. Lap → LAP, capturing bcd_live into lap_reg.
  - LAP: run → PAUSE, releasing the freeze. Lap → RUN, releasing the freeze. Counting continues throughout LAP.
  - PAUSE: run → RUN. Lap → IDLE, with a ctr_clr pulse.
- Simultaneous run and lap presses in the same cycle: run wins; the lap press is discarded and lap_reg is unchanged.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0, only in RUN/LAP.
  - Holds its value in PAUSE, so resuming preserves the partial period.
  - Cleared on entry to RUN from IDLE and on entry to IDLE.
- bcd_disp: lap_reg in LAP, bcd_live in every other state (combinational mux). Digit values are passed through unchecked; non-BCD codes are not corrected.
- lap_reg samples bcd_live at the RUN→LAP edge. If ctr_en is high in that same cycle, the pre-increment value is captured.

## Timing
- Key → state latency: the state changes on the 3rd rising clk edge after key_n is first sampled low. running and lap_active are registered and change on that same edge.
- ctr_en:
  - Registered, exactly one cycle high per TICK_DIV clocks while in RUN/LAP.
  - First pulse is TICK_DIV cycles after the edge entering RUN from IDLE.
  - Leaving RUN/LAP on an edge where a pulse would be issued suppresses that pulse.
- ctr_clr is registered and high for exactly the first IDLE cycle after PAUSE→IDLE. ctr_en is never high in the same cycle as ctr_clr.
- ar assertion: every state element returns to its reset value immediately, independent of clk. Deassertion is expected to be synchronized upstream.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state, lap_reg and the bcd_disp mux are present, as described above.
- Not defined:
  - No LAP state and no lap_reg.
  - Lap press in RUN is ignored; lap press in PAUSE still clears to IDLE.
  - lap_active is tied 0 and bcd_disp = bcd_live.

## Structure
- stopwatch_pkg holds:
  - state typedef (IDLE, RUN, PAUSE, LAP) and its encodings
  - BCD_W = 24
  - TICK_DIV default constant
- Sub-module key_press_det (sync, history flop, press pulse), instantiated once per key. FSM, prescaler and lap register live in stopwatch_ctrl.

## Test plan
- Reset with keys released, TICK_DIV=4 → all outputs 0 and bcd_disp = bcd_live. No ctr_en over 40 cycles; no press event after ar release.
- Run press from IDLE, TICK_DIV=4 → running=1 on the 3rd edge. ctr_en pulses 4, 8, 12, 16, 20 cycles after entry: 5 single-cycle pulses in 20 cycles.
- In RUN with bcd_live=24'h000123, lap press → lap_active=1 and bcd_disp holds 24'h000123 while bcd_live advances to 24'h000130. Second lap press → bcd_disp tracks live again and running stays 1.
- Pause 2 cycles into a 4-cycle period, wait 50 cycles, resume → next ctr_en exactly 2 cycles after re-entering RUN.
- In PAUSE, lap press → ctr_clr high for exactly 1 cycle, state IDLE, running=0, no ctr_en. Build without STOPWATCH_LAP_EN: lap press in RUN → no state change.
- Run and lap falling in the same cycle in RUN → PAUSE with lap_reg unchanged. ar low mid-LAP → all outputs at reset values before the next clk edge.
